piece_bag_generator: RTL and testbench
======================================

// Module: piece_bag_generator
// PURPOSE
//  Upstream feeder of game_executioner: supplies the next falling piece on new_piece.
//  Uses 7-bag randomisation: every aligned group of 7 delivered pieces is a permutation of all 7 types.
//  Keeps a small FIFO of pre-drawn pieces, so the head is always valid and a preview is available.
//  Single clock domain (clk). The consumer pulses consume for one clk cycle when it latches new_piece.
// PARAMETERS
//  PREVIEW_DEPTH  3          preview entries exported beyond the head; FIFO depth = PREVIEW_DEPTH+1
//  LFSR_SEED      16'hACE1   seed loaded at reset; also used when seed_load carries 0
//  SPAWN_X        4          x field of every emitted piece
//  MAX_REJECT     8          rejected LFSR draws allowed before the deterministic fallback
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  consume        in   1      one-cycle pop request for the head piece
//  seed_load      in   1      one-cycle pulse: reseed and flush
//  seed_entropy   in   16     seed value sampled on seed_load
//  new_piece      out  tetris_pkg::active_piece_t  head piece {x=SPAWN_X, y=0, rotation=ROT_0, piece_type}
//  piece_valid    out  1      FIFO holds >=1 entry
//  preview_type   out  tetris_pkg::piece_type_t [PREVIEW_DEPTH]  entries head+1..head+PREVIEW_DEPTH; invalid entries read 0
//  underflow      out  1      sticky; set by consume while !piece_valid
// BEHAVIOUR
//  Reset values
//   - FIFO empty; bag_used=7'b0; LFSR=LFSR_SEED; FSM=DRAW.
//   - Outputs: piece_valid=0, underflow=0, preview_type all 0.
//   - new_piece={SPAWN_X, 0, ROT_0, type 0}.
//  LFSR
//   - 16-bit Galois, mask 16'hB400, advances every cycle out of reset.
//   - If the LFSR ever holds 0, it loads LFSR_SEED next cycle.
//  FSM: DRAW / FULL
//   - DRAW: candidate = lfsr[2:0].
//     - Accept when candidate<7 and bag_used[candidate]=0.
//     - Otherwise reject and increment reject_cnt.
//     - When reject_cnt==MAX_REJECT: accept the lowest-index unused type that cycle; clear reject_cnt.
//     - Accepting pushes the type into the FIFO and sets its bag_used bit.
//     - If bag_used would become 7'h7F, it clears to 0 in that same cycle.
//   - DRAW -> FULL when count reaches PREVIEW_DEPTH+1 after a push.
//   - FULL -> DRAW on any pop.
//   - Worst-case draw latency: MAX_REJECT+1 cycles.
//  Pop and push timing
//   - consume with piece_valid pops the head; new_piece shows the next entry the following cycle.
//   - Push and pop in the same cycle: both execute, count unchanged.
//   - Push into a full FIFO cannot occur (FSM stalls in FULL).
//  Errors
//   - consume with !piece_valid: no state change except underflow<=1.
//   - underflow clears only on reset or seed_load.
//  Outputs
//   - new_piece and preview_type are registered views of the FIFO, zero combinational path from consume.
//   - piece_valid deasserts the cycle after the last entry is popped.
//  seed_load
//   - Next cycle: LFSR=seed_entropy (LFSR_SEED if 0), FIFO flushed, bag_used=0, reject_cnt=0, FSM=DRAW, underflow=0.
//   - seed_load beats a simultaneous consume; reset beats both.
//  Reset mid-draw: abandons any partial draw; no stale entry survives.
// STRUCTURE
//  tetris_pkg gains:
//   - BAG_SIZE=7.
//   - piece_type_t encoding I=0,O=1,T=2,S=3,Z=4,J=5,L=6.
//   - gen_state_t {GEN_DRAW, GEN_FULL}.
//  Sub-module galois_lfsr16 (seed, load, en -> state); FIFO and bag logic stay inline.
// TESTING
//  1. Reset, no consume -> piece_valid within 4*(MAX_REJECT+1)+2 cycles; FSM FULL; all 3 preview entries valid.
//  2. 7 consumes spaced 20 cycles -> the 7 types form a permutation of {0..6}; repeat 10 bags -> each type appears exactly 10 times.
//  3. consume at reset+1 (FIFO empty) -> underflow=1 and stays; FIFO unaffected; next valid piece still drawn normally.
//  4. seed_load seed 16'h1234, record 14 pieces; seed_load 16'h1234 again -> identical 14-piece sequence; seed 0 -> same sequence as LFSR_SEED.
//  5. Force rejects by holding the LFSR on a used type -> fallback picks the lowest unused type after exactly 8 rejects.
//  6. consume on the cycle a push lands -> count unchanged; head advances; no entry lost or duplicated (scoreboard).

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tetris_pkg
// Brief   : Shared piece, rotation and generator-state types for the game core.
// Rev     : 1.0  initial release
// ============================================================================
package tetris_pkg;

    localparam int BAG_SIZE = 7;
    localparam int X_W      = 4;
    localparam int Y_W      = 5;

    localparam logic [BAG_SIZE-1:0] BAG_ALL = '1;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_type_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rotation_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        rotation_t      rotation;
        piece_type_t    piece_type;
    } active_piece_t;

    typedef enum logic [0:0] {
        GEN_DRAW = 1'b0,
        GEN_FULL = 1'b1
    } gen_state_t;

    // Caller guarantees at least one bit of used is clear.
    function automatic piece_type_t lowest_unused(input logic [BAG_SIZE-1:0] used);
        piece_type_t r;
        r = PIECE_I;
        for (int i = BAG_SIZE - 1; i >= 0; i--) begin
            if (!used[i]) begin
                r = piece_type_t'(i[2:0]);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/galois_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : galois_lfsr16
// Brief   : 16-bit Galois LFSR with synchronous seed load and lock-up recovery.
// Rev     : 1.0  initial release
// ============================================================================
module galois_lfsr16 #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] MASK      = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] w_step;

    always_comb begin
        w_step  = {1'b0, state_q[15:1]} ^ (state_q[0] ? MASK : 16'h0000);
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
        end else if (state_q == 16'h0000) begin
            // The all-zero state is a fixed point; kick it back onto the sequence.
            state_d = LFSR_SEED;
        end else if (en_i) begin
            state_d = w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/piece_bag_generator.sv
`default_nettype none
// ============================================================================
// Module  : piece_bag_generator
// Brief   : 7-bag randomised piece feeder with a small pre-drawn FIFO and preview.
// Rev     : 1.0  initial release
// ============================================================================
module piece_bag_generator
    import tetris_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SPAWN_X       = 4,
    parameter int          MAX_REJECT    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          consume,
    input  logic          seed_load,
    input  logic [15:0]   seed_entropy,
    output active_piece_t new_piece,
    output logic          piece_valid,
    output piece_type_t   preview_type [PREVIEW_DEPTH],
    output logic          underflow
);

    localparam int DEPTH = PREVIEW_DEPTH + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int REJ_W = $clog2(MAX_REJECT + 1);

    logic [15:0]         w_lfsr;
    logic [12:0]         lfsr_hi_unused;

    piece_type_t         fifo_q [DEPTH];
    piece_type_t         fifo_d [DEPTH];
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic [BAG_SIZE-1:0] bag_q;
    logic [BAG_SIZE-1:0] bag_d;
    logic [REJ_W-1:0]    rej_q;
    logic [REJ_W-1:0]    rej_d;
    gen_state_t          state_q;
    logic                valid_q;
    logic                underflow_q;

    logic [2:0]          w_cand;
    logic [7:0]          w_used_ext;
    logic                w_pop;
    logic                w_push;
    piece_type_t         w_push_type;
    logic [BAG_SIZE-1:0] w_bag_set;
    logic [CNT_W-1:0]    w_wr_idx;

    galois_lfsr16 #(
        .LFSR_SEED (LFSR_SEED),
        .MASK      (16'hB400)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed_i  (seed_entropy),
        .load_i  (seed_load),
        .en_i    (1'b1),
        .state_o (w_lfsr)
    );

    assign lfsr_hi_unused = w_lfsr[15:3];

    // Draw logic: candidate 7 maps onto the always-set pad bit so it rejects.
    always_comb begin
        w_cand      = w_lfsr[2:0];
        w_used_ext  = {1'b1, bag_q};
        w_pop       = consume && valid_q;
        w_push      = 1'b0;
        w_push_type = PIECE_I;
        w_bag_set   = bag_q;
        rej_d       = rej_q;
        bag_d       = bag_q;
        if (state_q == GEN_DRAW) begin
            if (!w_used_ext[w_cand]) begin
                w_push      = 1'b1;
                w_push_type = piece_type_t'(w_cand);
            end else if (rej_q == REJ_W'(MAX_REJECT)) begin
                w_push      = 1'b1;
                w_push_type = lowest_unused(bag_q);
            end else begin
                rej_d = rej_q + REJ_W'(1);
            end
        end
        if (w_push) begin
            rej_d     = '0;
            w_bag_set = bag_q | (BAG_SIZE'(1) << w_push_type);
            bag_d     = (w_bag_set == BAG_ALL) ? '0 : w_bag_set;
        end
    end

    // FIFO as a shift register: pop shifts toward the head, push lands just past the tail.
    always_comb begin
        w_wr_idx = count_q - CNT_W'(w_pop);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        for (int i = 0; i < DEPTH - 1; i++) begin
            fifo_d[i] = w_pop ? fifo_q[i+1] : fifo_q[i];
        end
        fifo_d[DEPTH-1] = w_pop ? PIECE_I : fifo_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_wr_idx == CNT_W'(i))) begin
                fifo_d[i] = w_push_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= PIECE_I;
            end
            count_q     <= '0;
            bag_q       <= '0;
            rej_q       <= '0;
            state_q     <= GEN_DRAW;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            fifo_q  <= fifo_d;
            count_q <= count_d;
            bag_q   <= bag_d;
            rej_q   <= rej_d;
            valid_q <= (count_d != '0);
            if (consume && !valid_q) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                GEN_DRAW: if (w_push && (count_d == CNT_W'(DEPTH))) state_q <= GEN_FULL;
                GEN_FULL: if (w_pop) state_q <= GEN_DRAW;
                default:  state_q <= GEN_DRAW;
            endcase
        end
    end

    always_comb begin
        new_piece            = '0;
        new_piece.x          = X_W'(SPAWN_X);
        new_piece.y          = '0;
        new_piece.rotation   = ROT_0;
        new_piece.piece_type = fifo_q[0];
    end

    generate
        for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
            assign preview_type[g] = fifo_q[g+1];
        end
    endgenerate

    assign piece_valid = valid_q;
    assign underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_bag_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_piece_bag_generator
// Brief   : Randomised scoreboard bench for piece_bag_generator.
// Rev     : 1.0  initial release
// ============================================================================
module tb_piece_bag_generator;
    import tetris_pkg::*;

    localparam int          PD    = 3;
    localparam int          DEPTH = PD + 1;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          SX    = 4;
    localparam int          MR    = 8;
    localparam int          FILL_BOUND = 4 * (MR + 1) + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          consume = 1'b0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed_entropy = 16'h0000;
    active_piece_t new_piece;
    logic          piece_valid;
    piece_type_t   preview_type [PD];
    logic          underflow;

    piece_bag_generator #(
        .PREVIEW_DEPTH (PD),
        .LFSR_SEED     (SEED),
        .SPAWN_X       (SX),
        .MAX_REJECT    (MR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .consume      (consume),
        .seed_load    (seed_load),
        .seed_entropy (seed_entropy),
        .new_piece    (new_piece),
        .piece_valid  (piece_valid),
        .preview_type (preview_type),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bag rules applied to a queue, one step per clock edge.
    logic [15:0] m_lfsr;
    int          m_q[$];
    bit [6:0]    m_bag;
    int          m_rej;
    bit          m_uf;
    int          exp_q[$];
    int          m_fallbacks = 0;
    int          m_pushpop = 0;
    bit          started = 1'b0;

    function automatic logic [15:0] galois_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk) begin : model
        int drawn;
        int c;
        started = 1'b1;
        drawn = -1;
        if (reset) begin
            m_lfsr = SEED; m_q.delete(); exp_q.delete(); m_bag = '0; m_rej = 0; m_uf = 1'b0;
        end else if (seed_load) begin
            m_lfsr = (seed_entropy == 16'h0000) ? SEED : seed_entropy;
            m_q.delete(); exp_q.delete(); m_bag = '0; m_rej = 0; m_uf = 1'b0;
        end else begin
            if (m_q.size() < DEPTH) begin
                c = int'(m_lfsr % 8);
                if (c < 7 && !m_bag[c]) begin
                    drawn = c;
                end else if (m_rej == MR) begin
                    for (int t = 6; t >= 0; t--) if (!m_bag[t]) drawn = t;
                    m_fallbacks++;
                end else begin
                    m_rej++;
                end
            end
            if (consume) begin
                if (m_q.size() == 0) m_uf = 1'b1;
                else begin
                    void'(m_q.pop_front());
                    if (drawn >= 0) m_pushpop++;
                end
            end
            if (drawn >= 0) begin
                m_rej = 0;
                m_bag[drawn] = 1'b1;
                if (m_bag == 7'h7F) m_bag = '0;
                m_q.push_back(drawn);
                exp_q.push_back(drawn);
            end
            m_lfsr = (m_lfsr == 16'h0000) ? SEED : galois_next(m_lfsr);
        end
    end

    // Monitor: state snapshot vs model, and scoreboard pop on every accepted consume.
    bit [6:0] bag_seen = '0;
    int       bag_n = 0;
    int       hist [7];

    always @(negedge clk) begin : monitor
        int e;
        int t;
        if (started) begin
            check("valid", int'(piece_valid), (m_q.size() != 0) ? 1 : 0);
            check("head", int'(new_piece.piece_type), (m_q.size() != 0) ? m_q[0] : 0);
            check("spawn_fields", int'({new_piece.x, new_piece.y, new_piece.rotation}), SX * 128);
            for (int i = 0; i < PD; i++) begin
                check("preview", int'(preview_type[i]), (m_q.size() > i + 1) ? m_q[i+1] : 0);
            end
            check("underflow", int'(underflow), int'(m_uf));
            if (reset || seed_load) begin
                bag_seen = '0;
                bag_n = 0;
            end else if (consume && piece_valid) begin
                t = int'(new_piece.piece_type);
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pop", t, e);
                end
                check("bag_type_range", (t < 7) ? 1 : 0, 1);
                if (t < 7) begin
                    check("bag_perm", int'(bag_seen[t]), 0);
                    bag_seen[t] = 1'b1;
                    hist[t]++;
                end
                bag_n++;
                if (bag_n == 7) begin
                    bag_n = 0;
                    bag_seen = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; consume = 1'b0; seed_load = 1'b0;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed_entropy = s; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic pop_one(input string name);
        int k;
        k = 0;
        while (!piece_valid && k < FILL_BOUND) begin
            tick();
            k++;
        end
        check(name, int'(piece_valid), 1);
        if (piece_valid) begin
            consume = 1'b1;
            tick();
            consume = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int k;
        for (int i = 0; i < 7; i++) hist[i] = 0;

        // Fill from reset without consuming
        cycles(3);
        reset = 1'b0;
        k = 0;
        while (!piece_valid && k < FILL_BOUND) begin
            tick();
            k++;
        end
        check("fill_after_reset", int'(piece_valid), 1);
        cycles(FILL_BOUND);

        // Underflow on the first cycle out of reset
        do_reset();
        consume = 1'b1;
        tick();
        consume = 1'b0;
        cycles(30);
        check("underflow_sticky", int'(underflow), 1);
        pop_one("post_underflow_pop");

        // Reseed determinism, including the zero-seed substitution
        for (int r = 0; r < 3; r++) begin
            do_seed((r == 2) ? 16'h0000 : 16'h1234);
            for (int p = 0; p < 14; p++) begin
                pop_one("seed_pop");
                cycles(r + 1);
            end
        end
        check("underflow_cleared_by_seed", int'(underflow), 0);

        // Ten spaced bags: each type exactly ten times
        do_seed(16'h5A5A);
        for (int i = 0; i < 7; i++) hist[i] = 0;
        for (int p = 0; p < 70; p++) begin
            cycles(20);
            pop_one("bag_pop");
        end
        for (int i = 0; i < 7; i++) check("hist_10_bags", hist[i], 10);

        // Random traffic: back-to-back consumes, reseeds, resets, underflows
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            consume      = ($urandom_range(0, 99) < 45);
            seed_entropy = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            seed_load    = ($urandom_range(0, 399) == 0);
            reset        = ($urandom_range(0, 799) == 0);
            tick();
        end
        consume = 1'b0; seed_load = 1'b0; reset = 1'b0;
        cycles(5);

        check("fallback_exercised", (m_fallbacks > 0) ? 1 : 0, 1);
        check("push_pop_same_cycle_exercised", (m_pushpop > 0) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
